// File: rtl/processor_control.sv
// rtl/processor_control.sv - multicycle datapath control unit: fetch, decode and 1-3 execute cycles
module processor_control #(
    parameter int IW   = 8,
    parameter int SW_W = 4
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [15:0]     isr,
    output logic [15:0]     rout,
    output logic [15:0]     ren,
    output logic            addxor,
    output logic            increment,
    output logic            done,
    output logic [SW_W-1:0] currstate,
    output logic [SW_W-1:0] nextstate,
    output logic [1:0]      opcode
);

    typedef enum logic [SW_W-1:0] {
        ST_IDLE  = SW_W'(0),
        ST_FETCH = SW_W'(1),
        ST_EX1   = SW_W'(2),
        ST_EX2   = SW_W'(3),
        ST_EX3   = SW_W'(4)
    } state_t;

    localparam logic [1:0] OP_MV  = 2'b00;
    localparam logic [1:0] OP_MVI = 2'b01;

    localparam int B_G      = 8;
    localparam int B_A      = 9;
    localparam int B_EXTERN = 10;
    localparam int B_ISR    = 11;

    logic [SW_W-1:0] state_q;
    logic [SW_W-1:0] state_d;
    logic [2:0]      rx;
    logic [2:0]      ry;
    logic            unused_isr;

    assign opcode     = isr[IW-1:IW-2];
    assign rx         = isr[IW-3:IW-5];
    assign ry         = isr[IW-6:IW-8];
    assign unused_isr = ^isr[15:IW];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = ST_IDLE;
        rout      = 16'h0000;
        ren       = 16'h0000;
        addxor    = 1'b0;
        increment = 1'b0;
        done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                state_d = run ? ST_FETCH : ST_IDLE;
            end
            ST_FETCH: begin
                rout[B_EXTERN] = 1'b1;
                ren[B_ISR]     = 1'b1;
                increment      = 1'b1;
                state_d        = ST_EX1;
            end
            ST_EX1: begin
                if (opcode == OP_MV) begin
                    rout[ry] = 1'b1;
                    ren[rx]  = 1'b1;
                    done     = 1'b1;
                    state_d  = run ? ST_FETCH : ST_IDLE;
                end else if (opcode == OP_MVI) begin
                    rout[B_EXTERN] = 1'b1;
                    ren[rx]        = 1'b1;
                    increment      = 1'b1;
                    done           = 1'b1;
                    state_d        = run ? ST_FETCH : ST_IDLE;
                end else begin
                    rout[rx] = 1'b1;
                    ren[B_A] = 1'b1;
                    state_d  = ST_EX2;
                end
            end
            ST_EX2: begin
                rout[ry] = 1'b1;
                ren[B_G] = 1'b1;
                addxor   = opcode[0];
                state_d  = ST_EX3;
            end
            ST_EX3: begin
                rout[B_G] = 1'b1;
                ren[rx]   = 1'b1;
                done      = 1'b1;
                state_d   = run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign currstate = state_q;
    assign nextstate = reset ? SW_W'(0) : state_d;

endmodule
